// File: rtl/fstore_pkg.sv
// Shared definitions for the frame-store port B access logic.
// Frame geometry, the fill character, the ASCII control codes handled by the
// character path, and the enums used by the arbiter.
package fstore_pkg;

  localparam int unsigned FS_COLS_LOG2 = 7;
  localparam int unsigned FS_ROWS_LOG2 = 6;
  localparam int unsigned FS_ADDR_W    = FS_COLS_LOG2 + FS_ROWS_LOG2;
  localparam logic [7:0]  FS_BLANK_CH  = 8'h20;

  localparam logic [6:0] FS_BS = 7'h08;
  localparam logic [6:0] FS_LF = 7'h0A;
  localparam logic [6:0] FS_FF = 7'h0C;
  localparam logic [6:0] FS_CR = 7'h0D;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic {GNT_CHAR, GNT_HOST} gnt_t;

endpackage

// File: rtl/fstore_cursor.sv
// Terminal cursor and character decode for the frame-store character path.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   home            force cursor to row 0 / col 0 (clear screen)
//   step            character in ch accepted this cycle; advance cursor
//   ch              character under decode
//   row, col        registered cursor position
//   wr              character needs a frame-store write
//   wr_addr/wr_data address/data of that write
//   ff              character is form feed (caller starts a clear)
module fstore_cursor
  import fstore_pkg::*;
#(
  parameter int unsigned  COLS_LOG2 = FS_COLS_LOG2,
  parameter int unsigned  ROWS_LOG2 = FS_ROWS_LOG2,
  parameter logic [7:0]   BLANK_CH  = FS_BLANK_CH,
  localparam int unsigned ADDR_W    = COLS_LOG2 + ROWS_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 home,
  input  logic                 step,
  input  logic [6:0]           ch,
  output logic [ROWS_LOG2-1:0] row,
  output logic [COLS_LOG2-1:0] col,
  output logic                 wr,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data,
  output logic                 ff
);

  logic [ROWS_LOG2-1:0] row_nx;
  logic [COLS_LOG2-1:0] col_nx;
  logic [ROWS_LOG2-1:0] row_inc;
  logic [COLS_LOG2-1:0] col_inc;
  logic [COLS_LOG2-1:0] col_dec;

  // Row increment wraps from the last row to row 0; there is no scrolling.
  assign row_inc = row + ROWS_LOG2'(1);
  assign col_inc = col + COLS_LOG2'(1);
  assign col_dec = col - COLS_LOG2'(1);

  always_comb begin
    row_nx  = row;
    col_nx  = col;
    wr      = 1'b0;
    wr_addr = {row, col};
    wr_data = {1'b0, ch};
    ff      = 1'b0;
    if (ch >= 7'h20 && ch <= 7'h7E) begin
      wr = 1'b1;
      if (col == '1) begin
        col_nx = '0;
        row_nx = row_inc;
      end else begin
        col_nx = col_inc;
      end
    end else begin
      case (ch)
        FS_LF: begin
          col_nx = '0;
          row_nx = row_inc;
        end
        FS_CR: col_nx = '0;
        FS_BS: begin
          if (col != '0) begin
            col_nx  = col_dec;
            wr      = 1'b1;
            wr_addr = {row, col_dec};
            wr_data = BLANK_CH;
          end
        end
        FS_FF:   ff = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || home) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      row <= row_nx;
      col <= col_nx;
    end
  end

endmodule

// File: rtl/fstore_port_arb.sv
// Frame-store port B sequencer: clear engine, terminal character stream and
// host word port share one registered RAM port.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ch_valid, ch_data, ch_ready       character stream handshake
//   host_req/we/addr/wdata, host_gnt  host access request and grant
//   host_rvalid, host_rdata           host read return (2 cycles after grant)
//   clr_req, busy                     clear request pulse, clear engine active
//   cursor_row, cursor_col            terminal cursor position
//   fb_addr/din/we/en, fb_dout        frame-store port B
module fstore_port_arb
  import fstore_pkg::*;
#(
  parameter int unsigned  COLS_LOG2 = FS_COLS_LOG2,
  parameter int unsigned  ROWS_LOG2 = FS_ROWS_LOG2,
  parameter logic [7:0]   BLANK_CH  = FS_BLANK_CH,
  localparam int unsigned ADDR_W    = COLS_LOG2 + ROWS_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ch_valid,
  input  logic [6:0]           ch_data,
  output logic                 ch_ready,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [7:0]           host_rdata,
  input  logic                 clr_req,
  output logic                 busy,
  output logic [ROWS_LOG2-1:0] cursor_row,
  output logic [COLS_LOG2-1:0] cursor_col,
  output logic [ADDR_W-1:0]    fb_addr,
  output logic [7:0]           fb_din,
  output logic                 fb_we,
  output logic                 fb_en,
  input  logic [7:0]           fb_dout
);

  state_t              state, state_nx;
  gnt_t                last_gnt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                host_win, char_win, go_clear;
  logic                cur_wr, cur_ff;
  logic [ADDR_W-1:0]   cur_addr;
  logic [7:0]          cur_data;

  fstore_cursor #(
    .COLS_LOG2 (COLS_LOG2),
    .ROWS_LOG2 (ROWS_LOG2),
    .BLANK_CH  (BLANK_CH)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .home    (go_clear),
    .step    (char_win),
    .ch      (ch_data),
    .row     (cursor_row),
    .col     (cursor_col),
    .wr      (cur_wr),
    .wr_addr (cur_addr),
    .wr_data (cur_data),
    .ff      (cur_ff)
  );

  // Round-robin between host and character stream; clr_req suppresses both.
  always_comb begin
    host_win = 1'b0;
    char_win = 1'b0;
    if (state == ST_RUN && !clr_req) begin
      if (host_req && (!ch_valid || last_gnt == GNT_CHAR)) host_win = 1'b1;
      else if (ch_valid)                                   char_win = 1'b1;
    end
  end

  assign host_gnt = host_win;
  assign ch_ready = char_win;
  assign go_clear = clr_req | (char_win & cur_ff);
  assign busy     = (state == ST_CLEAR);

  always_comb begin
    state_nx = state;
    if (go_clear)                              state_nx = ST_CLEAR;
    else if (state == ST_CLEAR && clr_cnt == '1) state_nx = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nx;
  end

  // Read data is exposed only in the rvalid cycle, when fb_dout holds the
  // word addressed two cycles earlier.
  assign host_rdata = host_rvalid ? fb_dout : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt     <= '0;
      last_gnt    <= GNT_CHAR;
      fb_en       <= 1'b0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_din      <= BLANK_CH;
      host_rvalid <= 1'b0;
    end else begin
      fb_en       <= 1'b0;
      fb_we       <= 1'b0;
      // Only the host issues reads, so a read on the port means a host read.
      host_rvalid <= fb_en & ~fb_we;
      if (state == ST_CLEAR) begin
        fb_en   <= 1'b1;
        fb_we   <= 1'b1;
        fb_addr <= clr_cnt;
        fb_din  <= BLANK_CH;
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end else if (host_win) begin
        last_gnt <= GNT_HOST;
        fb_en    <= 1'b1;
        fb_we    <= host_we;
        fb_addr  <= host_addr;
        fb_din   <= host_wdata;
      end else if (char_win) begin
        last_gnt <= GNT_CHAR;
        if (cur_wr) begin
          fb_en   <= 1'b1;
          fb_we   <= 1'b1;
          fb_addr <= cur_addr;
          fb_din  <= cur_data;
        end
      end
      if (go_clear) clr_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fstore_port_arb.sv
module tb_fstore_port_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [6:0]  ch_data = '0;
  logic        ch_ready;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [12:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_gnt;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic        clr_req = 1'b0;
  logic        busy;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [12:0] fb_addr;
  logic [7:0]  fb_din;
  logic        fb_we;
  logic        fb_en;
  logic [7:0]  fb_dout = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  din;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] mem [0:8191];

  always #5 clk = ~clk;

  fstore_port_arb #(
    .COLS_LOG2 (7),
    .ROWS_LOG2 (6),
    .BLANK_CH  (8'h20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .ch_ready    (ch_ready),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .clr_req     (clr_req),
    .busy        (busy),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .fb_addr     (fb_addr),
    .fb_din      (fb_din),
    .fb_we       (fb_we),
    .fb_en       (fb_en),
    .fb_dout     (fb_dout)
  );

  // Frame-store RAM model: one-cycle registered read.
  always @(posedge clk) begin
    if (fb_en === 1'b1) begin
      if (fb_we) mem[fb_addr] <= fb_din;
      else       fb_dout <= mem[fb_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic acc_t mk(input logic we, input logic [12:0] a, input logic [7:0] d);
    acc_t r;
    r.we = we; r.addr = a; r.din = d;
    return r;
  endfunction

  // Scoreboard: every port B access and every host read return is popped
  // from the expectation queues in order.
  always @(negedge clk) begin
    if (fb_en === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL fb_unexpected observed we=%0b addr=%0d din=%0h expected no access",
               fb_we, fb_addr, fb_din);
      end
      if (exp_q.size() != 0) begin
        acc_t e;
        e = exp_q.pop_front();
        chk("fb_we", fb_we, e.we);
        chk("fb_addr", fb_addr, e.addr);
        if (e.we) chk("fb_din", fb_din, e.din);
      end
    end
    if (host_rvalid === 1'b1) begin
      checks++;
      assert (rd_q.size() != 0) else begin
        errors++;
        $error("FAIL rvalid_unexpected observed rdata=%0h expected no rvalid", host_rdata);
      end
      if (rd_q.size() != 0) chk("host_rdata", host_rdata, rd_q.pop_front());
    end
  end

  task automatic push_clear();
    for (int i = 0; i < 8192; i++) exp_q.push_back(mk(1'b1, 13'(i), 8'h20));
  endtask

  // Called just after a posedge; returns on the negedge where busy dropped.
  task automatic wait_clear(input string tag, output int bad);
    int n;
    n = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy && (host_gnt || ch_ready)) bad++;
    end while (busy === 1'b1 && n < 9000);
    chk({tag, "_busy_drop"}, busy, 0);
    chk({tag, "_last_clear"}, {fb_en, fb_we, fb_addr}, {1'b1, 1'b1, 13'd8191});
  endtask

  task automatic send_ch(input logic [6:0] c, input bit w, input logic [12:0] a,
                         input logic [7:0] d);
    if (w) exp_q.push_back(mk(1'b1, a, d));
    ch_valid = 1'b1;
    ch_data  = c;
    @(negedge clk);
    chk("ch_ready", ch_ready, 1);
    @(posedge clk);
    #1 ch_valid = 1'b0;
  endtask

  initial begin
    int bad;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fb_en", fb_en, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_din", fb_din, 8'h20);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);

    // Power-up clear
    push_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear("pwr", bad);
    chk("pwr_cursor", {cursor_row, cursor_col}, 0);
    @(posedge clk);
    #1;

    // Character stream A, B, LF, C
    send_ch(7'h41, 1, 13'd0, 8'h41);
    send_ch(7'h42, 1, 13'd1, 8'h42);
    send_ch(7'h0A, 0, 13'd0, 8'h00);
    send_ch(7'h43, 1, 13'd128, 8'h43);
    @(negedge clk);
    chk("stream_cursor", {cursor_row, cursor_col}, {6'd1, 7'd1});
    @(posedge clk);
    #1;

    // Walk to row 63, col 127, then wrap
    for (int i = 0; i < 62; i++) send_ch(7'h0A, 0, 13'd0, 8'h00);
    send_ch(7'h0D, 0, 13'd0, 8'h00);
    for (int i = 0; i < 127; i++) send_ch(7'h78, 1, 13'(63 * 128 + i), 8'h78);
    @(negedge clk);
    chk("edge_cursor", {cursor_row, cursor_col}, {6'd63, 7'd127});
    @(posedge clk);
    #1;
    send_ch(7'h5A, 1, 13'd8191, 8'h5A);
    @(negedge clk);
    chk("wrap_cursor", {cursor_row, cursor_col}, 0);
    @(posedge clk);
    #1;
    send_ch(7'h08, 0, 13'd0, 8'h00);
    @(negedge clk);
    chk("bs_col0_cursor", {cursor_row, cursor_col}, 0);
    @(posedge clk);
    #1;

    // Host and character contend: H, C, H, C
    exp_q.push_back(mk(1'b0, 13'd128, 8'h00));
    exp_q.push_back(mk(1'b1, 13'd0, 8'h51));
    exp_q.push_back(mk(1'b0, 13'd128, 8'h00));
    exp_q.push_back(mk(1'b1, 13'd1, 8'h51));
    rd_q.push_back(8'h43);
    rd_q.push_back(8'h43);
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd128;
    ch_valid = 1'b1; ch_data = 7'h51;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_host_gnt", host_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_ch_ready", ch_ready, (i % 2 == 1) ? 1 : 0);
      chk("rr_rvalid", host_rvalid, (i == 2) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    host_req = 1'b0;
    ch_valid = 1'b0;
    @(negedge clk);
    chk("rr_rvalid2", host_rvalid, 1);
    chk("rr_cursor", {cursor_row, cursor_col}, {6'd0, 7'd2});
    @(posedge clk);
    #1;

    // Backspace from col 2 blanks col 1
    send_ch(7'h08, 1, 13'd1, 8'h20);
    @(negedge clk);
    chk("bs_cursor", {cursor_row, cursor_col}, {6'd0, 7'd1});
    @(posedge clk);
    #1;

    // clr_req against pending host and character requests
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd5; host_wdata = 8'h99;
    ch_valid = 1'b1; ch_data = 7'h52;
    clr_req = 1'b1;
    push_clear();
    exp_q.push_back(mk(1'b1, 13'd5, 8'h99));
    exp_q.push_back(mk(1'b1, 13'd0, 8'h52));
    @(negedge clk);
    chk("clr_host_gnt", host_gnt, 0);
    chk("clr_ch_ready", ch_ready, 0);
    @(posedge clk);
    #1 clr_req = 1'b0;
    wait_clear("req", bad);
    chk("clr_gnt_while_busy", bad, 0);
    chk("clr_resume_host", host_gnt, 1);
    chk("clr_resume_ch", ch_ready, 0);
    @(posedge clk);
    #1 host_req = 1'b0;
    @(negedge clk);
    chk("clr_resume_ch2", ch_ready, 1);
    @(posedge clk);
    #1 ch_valid = 1'b0;

    // Reset in the cycle after a host read grant
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd7;
    exp_q.push_back(mk(1'b0, 13'd7, 8'h00));
    @(negedge clk);
    chk("rrst_gnt", host_gnt, 1);
    @(posedge clk);
    #1 begin rst = 1'b1; host_req = 1'b0; end
    @(posedge clk);
    #1 rst = 1'b0;
    push_clear();
    @(negedge clk);
    chk("rrst_rvalid", host_rvalid, 0);
    chk("rrst_busy", busy, 1);
    chk("rrst_cursor", {cursor_row, cursor_col}, 0);
    @(posedge clk);
    #1;
    wait_clear("rrst", bad);
    chk("rrst_cursor_end", {cursor_row, cursor_col}, 0);

    repeat (2) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
